// File: rtl/ula_74181_seq.sv
// Nibble-serial ALU: one 74181-style slice reused over WIDTH/4 cycles, LSB nibble first,
// with the inter-nibble carry held in a register and Z/N/V flags computed at completion.

module ula_74181 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       c_i,
    output logic [3:0] f_o,
    output logic       c_o,
    output logic       eq_o
);
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // Active-high 74181: F = X plus Y plus C in arithmetic mode, XNOR(X,Y) in logic mode
    always_comb begin
        x    = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
        y    = (a_i & b_i & {4{s_i[3]}}) | (a_i & ~b_i & {4{s_i[2]}});
        sum  = {1'b0, x} + {1'b0, y} + {4'b0000, c_i};
        f_o  = m_i ? ~(x ^ y) : sum[3:0];
        c_o  = m_i ? 1'b0 : sum[4];
        eq_o = &f_o;
    end
endmodule

module ula_74181_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d, sa_q, sa_d, sb_q, sb_d, cy_q, cy_d, eq_q, eq_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d, aeqb_q, aeqb_d, zero_q, zero_d;
    logic             neg_q, neg_d, ovf_q, ovf_d;

    logic [3:0]       sl_f;
    logic             sl_c, sl_eq, sf;

    // Operand registers shift right each RUN cycle so the slice always sees bits [3:0]
    ula_74181 u_slice (
        .a_i  (a_q[3:0]),
        .b_i  (b_q[3:0]),
        .s_i  (s_q),
        .m_i  (m_q),
        .c_i  (cy_q),
        .f_o  (sl_f),
        .c_o  (sl_c),
        .eq_o (sl_eq)
    );

    assign sf = sl_f[3];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        s_d     = s_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cy_d    = cy_q;
        eq_d    = eq_q;
        f_d     = f_q;
        cout_d  = cout_q;
        aeqb_d  = aeqb_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    cy_d    = c_in;
                    eq_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_q >> 4;
                b_d    = b_q >> 4;
                work_d = {sl_f, work_q[WIDTH-1:4]};
                cy_d   = sl_c;
                eq_d   = eq_q & sl_eq;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IW'(NIB - 1)) begin
                    state_d = DONE;
                    f_d     = work_d;
                    cout_d  = m_q ? 1'b0 : sl_c;
                    aeqb_d  = eq_q & sl_eq;
                    zero_d  = (work_d == '0);
                    neg_d   = sf;
                    ovf_d   = 1'b0;
                    if (!m_q && s_q == 4'b1001)
                        ovf_d = (sa_q == sb_q) && (sf != sa_q);
                    else if (!m_q && s_q == 4'b0110)
                        ovf_d = (sa_q != sb_q) && (sf != sa_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cy_q    <= 1'b0;
            eq_q    <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cy_q    <= cy_d;
            eq_q    <= eq_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            aeqb_q  <= aeqb_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign f        = f_q;
    assign c_out    = cout_q;
    assign a_eq_b   = aeqb_q;
    assign zero     = zero_q;
    assign negative = neg_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ula_74181_seq.sv
// Directed bench for the nibble-serial ALU at WIDTH=16; expected values are hand-computed.

module tb_ula_74181_seq;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst, start, m, c_in;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       s;
    logic             busy, done, c_out, a_eq_b, zero, negative, overflow;
    logic [WIDTH-1:0] f;

    int n_cmp = 0;
    int n_err = 0;
    int cyc, bcnt;

    ula_74181_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
        .busy(busy), .done(done), .f(f), .c_out(c_out), .a_eq_b(a_eq_b),
        .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the accepting edge; returns at the negedge showing done
    task automatic wait_done(output int c, output int bc);
        c  = 0;
        bc = 0;
        while (!done && c < 20) begin
            if (busy) bc++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic [3:0] ts,
                         input logic tm, input logic tc);
        a = ta; b = tb_; s = ts; m = tm; c_in = tc; start = 1'b1;
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [3:0] ts,
                          input logic tm, input logic tc, input string tag);
        @(negedge clk);
        drive(ta, tb_, ts, tm, tc);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".lat"}, cyc, 4);
        chk({tag, ".busy_n"}, bcnt, 4);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ef, input logic ec,
                           input logic eq, input logic ez, input logic en, input logic ev);
        chk({tag, ".f"}, f, ef);
        chk({tag, ".c_out"}, c_out, ec);
        chk({tag, ".a_eq_b"}, a_eq_b, eq);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".neg"}, negative, en);
        chk({tag, ".ovf"}, overflow, ev);
    endtask

    initial begin
        // 1: reset held with start asserted
        rst = 1'b1;
        drive(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk_out("rst", 16'h0000, 0, 0, 0, 0, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst.nostart", busy, 0);

        // 2: signed add overflow
        run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, "add");
        chk_out("add", 16'h8000, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("add.pulse", done, 0);

        // 3: subtract minus one / exact subtract
        run_op(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b0, "subm1");
        chk_out("subm1", 16'hFFFF, 0, 1, 0, 1, 0);
        run_op(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1, "sub");
        chk_out("sub", 16'h0000, 1, 0, 1, 0, 0);

        // signed subtract overflow
        run_op(16'h8000, 16'h0001, 4'b0110, 1'b0, 1'b1, "subov");
        chk_out("subov", 16'h7FFF, 1, 0, 0, 0, 1);

        // 4: logic AND
        run_op(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, "and");
        chk_out("and", 16'hF000, 0, 0, 0, 1, 0);

        // 5: start during RUN is ignored; start in DONE is back-to-back
        @(negedge clk);
        drive(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        drive(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("ign.f_hold", f, 16'hF000);
        wait_done(cyc, bcnt);
        chk("ign.done", done, 1);
        chk("ign.lat", cyc, 2);
        chk_out("ign", 16'h8000, 0, 0, 0, 1, 1);
        drive(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b.f_hold", f, 16'h8000);
        wait_done(cyc, bcnt);
        chk("b2b.done", done, 1);
        chk("b2b.gap", cyc + 1, 5);
        chk_out("b2b", 16'h0000, 1, 0, 1, 0, 0);

        // 6: reset on 2nd RUN cycle aborts the operation
        @(negedge clk);
        drive(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("abort.busy1", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk_out("abort", 16'h0000, 0, 0, 0, 0, 0);
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) bcnt++;
        end
        chk("abort.quiet", bcnt, 0);
        run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, "fresh");
        chk_out("fresh", 16'h2345, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
